// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, grant encoding and
// the user-address field widths also used by the SDRAM controller.
package sdram_arb_pkg;

  localparam int unsigned BANK_W = 2;
  localparam int unsigned ROW_W  = 13;
  localparam int unsigned COL_W  = 9;
  localparam int unsigned ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACC,
    ST_WAIT_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VID,
    GNT_UART
  } arb_gnt_t;

  // Command latched for the controller; held from ISSUE until the next grant.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Client and controller-facing signals of the SDRAM port arbiter.
interface sdram_port_arbiter_if;
  import sdram_arb_pkg::*;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [WORD_W-1:0] vid_rdata;
  logic              vid_rvalid;
  logic              uart_req;
  logic [ADDR_W-1:0] uart_addr;
  logic [WORD_W-1:0] uart_wdata;
  logic              uart_ack;
  logic              arb_err;
  logic              mem_enable;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_busy;
  logic              mem_valid;
  logic [WORD_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  vid_req, vid_addr, uart_req, uart_addr, uart_wdata,
           mem_busy, mem_valid, mem_rdata,
    output vid_ack, vid_rdata, vid_rvalid, uart_ack, arb_err,
           mem_enable, mem_rw, mem_addr, mem_wdata
  );

  // Clients plus controller side.
  modport master (
    output vid_req, vid_addr, uart_req, uart_addr, uart_wdata,
           mem_busy, mem_valid, mem_rdata,
    input  vid_ack, vid_rdata, vid_rvalid, uart_ack, arb_err,
           mem_enable, mem_rw, mem_addr, mem_wdata
  );

endinterface

// File: rtl/sdram_arb_priority.sv
// Winner select: video has fixed priority unless UART has waited a full video run.
module sdram_arb_priority
  import sdram_arb_pkg::*;
(
  input  logic     vid_req,
  input  logic     uart_req,
  input  logic     run_sat,
  output arb_gnt_t gnt_c
);

  always_comb begin
    gnt_c = GNT_NONE;
    if (vid_req && !(uart_req && run_sat)) begin
      gnt_c = GNT_VID;
    end else if (uart_req) begin
      gnt_c = GNT_UART;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller user port between the video burst-read client and
// the UART single-write client, with a starvation limit on consecutive video grants.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ReadBurstLength = 8,
  parameter int unsigned MaxVideoRun     = 4,
  parameter int unsigned AcceptTimeout   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  sdram_port_arbiter_if.slave   bus
);

  localparam int unsigned BEAT_W = $clog2(ReadBurstLength + 1);
  localparam int unsigned RUN_W  = $clog2(MaxVideoRun + 1);
  localparam int unsigned TMO_W  = $clog2(AcceptTimeout + 1);

  arb_state_t        state_q, state_d;
  arb_gnt_t          gnt_q, gnt_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              mem_enable_q, mem_enable_d;
  logic              vid_ack_q, vid_ack_d;
  logic              uart_ack_q, uart_ack_d;
  logic              vid_rvalid_q, vid_rvalid_d;
  logic [WORD_W-1:0] vid_rdata_q, vid_rdata_d;
  logic              arb_err_q, arb_err_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  arb_gnt_t win_c;
  logic     run_sat_c;
  logic     vid_active_c;

  assign run_sat_c    = (run_q == RUN_W'(MaxVideoRun));
  assign vid_active_c = (gnt_q == GNT_VID) && (state_q != ST_IDLE);

  sdram_arb_priority u_priority (
    .vid_req  (bus.vid_req),
    .uart_req (bus.uart_req),
    .run_sat  (run_sat_c),
    .gnt_c    (win_c)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    cmd_d        = cmd_q;
    mem_enable_d = 1'b0;
    vid_ack_d    = 1'b0;
    uart_ack_d   = 1'b0;
    vid_rvalid_d = 1'b0;
    vid_rdata_d  = vid_rdata_q;
    arb_err_d    = arb_err_q;
    run_d        = run_q;
    beat_d       = beat_q;
    tmo_d        = tmo_q;

    // Read beats are only forwarded while a video command owns the controller.
    if (vid_active_c && bus.mem_valid) begin
      vid_rvalid_d = 1'b1;
      vid_rdata_d  = bus.mem_rdata;
      if (beat_q != BEAT_W'(ReadBurstLength)) begin
        beat_d = beat_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!bus.mem_busy && (win_c != GNT_NONE)) begin
          gnt_d        = win_c;
          beat_d       = '0;
          mem_enable_d = 1'b1;
          state_d      = ST_ISSUE;
          if (win_c == GNT_VID) begin
            cmd_d.rw    = 1'b1;
            cmd_d.addr  = bus.vid_addr;
            cmd_d.wdata = '0;
          end else begin
            cmd_d.rw    = 1'b0;
            cmd_d.addr  = bus.uart_addr;
            cmd_d.wdata = bus.uart_wdata;
          end
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_ACC;
      end
      ST_WAIT_ACC: begin
        if (bus.mem_busy) begin
          vid_ack_d  = (gnt_q == GNT_VID);
          uart_ack_d = (gnt_q == GNT_UART);
          state_d    = ST_WAIT_DONE;
        end else if (tmo_q == TMO_W'(AcceptTimeout - 1)) begin
          // Controller never took the command: flag it and let IDLE re-arbitrate.
          arb_err_d = 1'b1;
          gnt_d     = GNT_NONE;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.mem_busy &&
            ((gnt_q != GNT_VID) || (beat_q == BEAT_W'(ReadBurstLength)))) begin
          gnt_d   = GNT_NONE;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Count consecutive video wins only while UART is actually waiting.
    if (!bus.uart_req || uart_ack_d) begin
      run_d = '0;
    end else if (vid_ack_d && !run_sat_c) begin
      run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      gnt_q        <= GNT_NONE;
      cmd_q        <= '0;
      mem_enable_q <= 1'b0;
      vid_ack_q    <= 1'b0;
      uart_ack_q   <= 1'b0;
      vid_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      arb_err_q    <= 1'b0;
      run_q        <= '0;
      beat_q       <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      cmd_q        <= cmd_d;
      mem_enable_q <= mem_enable_d;
      vid_ack_q    <= vid_ack_d;
      uart_ack_q   <= uart_ack_d;
      vid_rvalid_q <= vid_rvalid_d;
      vid_rdata_q  <= vid_rdata_d;
      arb_err_q    <= arb_err_d;
      run_q        <= run_d;
      beat_q       <= beat_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.mem_enable = mem_enable_q;
  assign bus.mem_rw     = cmd_q.rw;
  assign bus.mem_addr   = cmd_q.addr;
  assign bus.mem_wdata  = cmd_q.wdata;
  assign bus.vid_ack    = vid_ack_q;
  assign bus.uart_ack   = uart_ack_q;
  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.vid_rdata  = vid_rdata_q;
  assign bus.arb_err    = arb_err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small behavioural SDRAM controller.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  logic CLK;
  logic RST;

  sdram_port_arbiter_if bus();

  sdram_port_arbiter #(
    .ReadBurstLength (8),
    .MaxVideoRun     (4),
    .AcceptTimeout   (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  // Controller model knobs.
  bit          force_busy = 1'b1;
  bit          accept     = 1'b1;
  logic [15:0] rd_base    = 16'hA0;

  // Observation state updated once per cycle at the falling edge.
  int          cyc      = 0;
  int          n_en     = 0;
  int          n_vack   = 0;
  int          n_uack   = 0;
  int          n_beat   = 0;
  int          first_en = -1;
  logic [15:0] seq      = '0;
  logic [15:0] beat_data [0:15];
  bit          ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (bus.mem_enable) begin
      n_en++;
      if (first_en < 0) first_en = cyc;
    end
    if (bus.vid_ack)  begin n_vack++; seq = {seq[14:0], 1'b1}; end
    if (bus.uart_ack) begin n_uack++; seq = {seq[14:0], 1'b0}; end
    if (bus.vid_rvalid) begin
      if (n_beat < 16) beat_data[n_beat] = bus.vid_rdata;
      n_beat++;
    end
  endtask

  task automatic clr();
    n_en = 0; n_vack = 0; n_uack = 0; n_beat = 0; first_en = -1; seq = '0;
  endtask

  // kind: 0 vid acks, 1 uart acks, 2 beats, 3 arb_err, 4 total acks
  task automatic run_until(input int kind, input int target, input int limit, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      tick();
      case (kind)
        0: hit = (n_vack >= target);
        1: hit = (n_uack >= target);
        2: hit = (n_beat >= target);
        3: hit = bus.arb_err;
        default: hit = ((n_vack + n_uack) >= target);
      endcase
    end
  endtask

  // Controller: busy on accept, 8-beat read return, 2-cycle write.
  initial begin
    bus.mem_busy  = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge CLK);
      if (force_busy) begin
        bus.mem_busy = 1'b1;
      end else if (bus.mem_enable && accept) begin
        bus.mem_busy = 1'b1;
        if (bus.mem_rw) begin
          for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            bus.mem_valid = 1'b1;
            bus.mem_rdata = rd_base + 16'(i);
          end
          @(negedge CLK);
          bus.mem_valid = 1'b0;
        end else begin
          @(negedge CLK);
        end
        @(negedge CLK);
        bus.mem_busy = 1'b0;
      end else begin
        bus.mem_busy = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0;
    bus.vid_req    = 1'b0;
    bus.vid_addr   = '0;
    bus.uart_req   = 1'b0;
    bus.uart_addr  = '0;
    bus.uart_wdata = '0;
    repeat (3) tick();

    check("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
    check("rst_mem_rw",     32'(bus.mem_rw),     32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    check("rst_vid_ack",    32'(bus.vid_ack),    32'd0);
    check("rst_uart_ack",   32'(bus.uart_ack),   32'd0);
    check("rst_vid_rvalid", 32'(bus.vid_rvalid), 32'd0);
    check("rst_arb_err",    32'(bus.arb_err),    32'd0);

    // Controller still initialising: request must wait.
    RST = 1'b1;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 24'h000100;
    clr();
    repeat (20) tick();
    check("t1_no_enable_while_busy", 32'(n_en), 32'd0);
    force_busy = 1'b0;

    // Single video burst.
    run_until(0, 1, 100, ok);
    check("t2_ack_seen", 32'(ok), 32'd1);
    bus.vid_req = 1'b0;
    run_until(2, 8, 50, ok);
    check("t2_beats_seen", 32'(ok), 32'd1);
    repeat (6) tick();
    check("t2_vid_acks", 32'(n_vack), 32'd1);
    check("t2_enables",  32'(n_en),   32'd1);
    check("t2_beats",    32'(n_beat), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_beat%0d", i), 32'(beat_data[i]), 32'h0A0 + 32'(i));
    end
    check("t2_mem_rw",   32'(bus.mem_rw),   32'd1);
    check("t2_mem_addr", 32'(bus.mem_addr), 32'h000100);

    // Single UART write.
    clr();
    bus.uart_req   = 1'b1;
    bus.uart_addr  = 24'h123456;
    bus.uart_wdata = 16'hBEEF;
    run_until(1, 1, 100, ok);
    check("t3_ack_seen", 32'(ok), 32'd1);
    bus.uart_req = 1'b0;
    repeat (5) tick();
    check("t3_uart_acks", 32'(n_uack),        32'd1);
    check("t3_vid_acks",  32'(n_vack),        32'd0);
    check("t3_enables",   32'(n_en),          32'd1);
    check("t3_mem_rw",    32'(bus.mem_rw),    32'd0);
    check("t3_mem_addr",  32'(bus.mem_addr),  32'h123456);
    check("t3_mem_wdata", 32'(bus.mem_wdata), 32'h0000BEEF);
    check("t3_no_beats",  32'(n_beat),        32'd0);

    // Both clients held: starvation limit interleaves UART after 4 video grants.
    clr();
    rd_base        = 16'h0010;
    bus.vid_req    = 1'b1;
    bus.vid_addr   = 24'h000200;
    bus.uart_req   = 1'b1;
    bus.uart_addr  = 24'h000042;
    bus.uart_wdata = 16'h5555;
    run_until(4, 10, 400, ok);
    bus.vid_req  = 1'b0;
    bus.uart_req = 1'b0;
    check("t4_acks_seen", 32'(ok), 32'd1);
    repeat (15) tick();
    check("t4_order",     32'(seq[9:0]), 32'(10'b1111011110));
    check("t4_vid_acks",  32'(n_vack),   32'd8);
    check("t4_uart_acks", 32'(n_uack),   32'd2);
    check("t4_beats",     32'(n_beat),   32'd64);

    // Controller never accepts: timeout, no ack, then retry succeeds.
    clr();
    accept         = 1'b0;
    bus.uart_req   = 1'b1;
    bus.uart_addr  = 24'h000010;
    bus.uart_wdata = 16'h1234;
    run_until(3, 1, 30, ok);
    check("t5_err_seen",    32'(ok),             32'd1);
    check("t5_err_latency", 32'(cyc - first_en), 32'd5);
    check("t5_no_ack",      32'(n_uack),         32'd0);
    check("t5_one_enable",  32'(n_en),           32'd1);
    accept = 1'b1;
    run_until(1, 1, 60, ok);
    check("t5_retry_ack",   32'(ok),          32'd1);
    check("t5_reissued",    32'(n_en),        32'd2);
    check("t5_err_sticky",  32'(bus.arb_err), 32'd1);
    bus.uart_req = 1'b0;
    repeat (5) tick();

    // Reset in the middle of a burst.
    clr();
    rd_base      = 16'h00C0;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 24'h000300;
    run_until(2, 3, 100, ok);
    check("t6_beat3_seen", 32'(ok), 32'd1);
    RST = 1'b0;
    bus.vid_req = 1'b0;
    #1;
    check("t6_mem_enable", 32'(bus.mem_enable), 32'd0);
    check("t6_mem_rw",     32'(bus.mem_rw),     32'd0);
    check("t6_mem_addr",   32'(bus.mem_addr),   32'd0);
    check("t6_vid_rvalid", 32'(bus.vid_rvalid), 32'd0);
    check("t6_vid_rdata",  32'(bus.vid_rdata),  32'd0);
    check("t6_arb_err",    32'(bus.arb_err),    32'd0);
    repeat (2) tick();
    RST = 1'b1;
    clr();
    repeat (30) tick();
    check("t6_no_more_beats", 32'(n_beat), 32'd0);
    check("t6_no_enable",     32'(n_en),   32'd0);
    check("t6_no_ack",        32'(n_vack), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
